addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pkg.sv | 8 +
 rtl/addsub_pipe_if.sv | 19 +
 rtl/addsub_core.sv | 25 ++
 rtl/addsub_pipe.sv | 65 ++++++
 tb/tb_addsub_pipe.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: opcode width and encodings shared by the add/sub pipeline
package addsub_pkg;
  localparam int OP_W = 2;
  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB  = 2'b01;
  localparam logic [OP_W-1:0] OP_ACC  = 2'b10;
  localparam logic [OP_W-1:0] OP_LOAD = 2'b11;
endpackage

// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: in side (in_valid/in_ready/op/a/b), out side (out_valid/out_ready/y/ovf), sticky flag (ovf_sticky/clr_sticky)
interface addsub_pipe_if #(parameter int W = 12);
  import addsub_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    y;
  logic            ovf;
  logic            ovf_sticky;
  logic            clr_sticky;
  modport master (output in_valid, op, a, b, out_ready, clr_sticky,
                  input in_ready, out_valid, y, ovf, ovf_sticky);
  modport slave  (input in_valid, op, a, b, out_ready, clr_sticky,
                  output in_ready, out_valid, y, ovf, ovf_sticky);
endinterface

// File: rtl/addsub_core.sv
// addsub_core: combinational add/sub/acc/load with carry/borrow flag and optional unsigned saturation; ports op,a,b,acc -> y,ovf
module addsub_core
  import addsub_pkg::*;
#(
  parameter int W   = 12,
  parameter int SAT = 0
) (
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    acc,
  output logic [W-1:0]    y,
  output logic            ovf
);
  logic [W:0]   add;
  logic [W:0]   sub;
  logic [W-1:0] raw;
  always_comb begin
    add = {1'b0, (op == OP_ACC) ? acc : a} + {1'b0, (op == OP_ACC) ? a : b};
    sub = {1'b0, a} - {1'b0, b};
    ovf = (op == OP_LOAD) ? 1'b0 : (op == OP_SUB) ? sub[W] : add[W];
    raw = (op == OP_LOAD) ? a : (op == OP_SUB) ? sub[W-1:0] : add[W-1:0];
    y   = (SAT != 0 && ovf) ? ((op == OP_SUB) ? {W{1'b0}} : {W{1'b1}}) : raw;
  end
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage valid/ready add/sub pipeline with accumulator and sticky overflow; ports clk, rst (async high), bus (addsub_pipe_if.slave)
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int W   = 12,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  addsub_pipe_if.slave  bus
);
  logic            en;
  logic            s1_v;
  logic [OP_W-1:0] s1_op;
  logic [W-1:0]    s1_a;
  logic [W-1:0]    s1_b;
  logic [W-1:0]    acc;
  logic [W-1:0]    res;
  logic            res_ovf;
  logic            stall;
  assign stall        = bus.out_valid && !bus.out_ready;
  // en keeps in_ready low until the first edge after reset releases
  assign bus.in_ready = en && (!s1_v || !stall);
  addsub_core #(.W(W), .SAT(SAT)) u_core (
    .op  (s1_op),
    .a   (s1_a),
    .b   (s1_b),
    .acc (acc),
    .y   (res),
    .ovf (res_ovf)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en             <= 1'b0;
      s1_v           <= 1'b0;
      s1_op          <= '0;
      s1_a           <= '0;
      s1_b           <= '0;
      acc            <= '0;
      bus.out_valid  <= 1'b0;
      bus.y          <= '0;
      bus.ovf        <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else begin
      en <= 1'b1;
      if (bus.in_ready) s1_v <= bus.in_valid;
      if (bus.in_ready && bus.in_valid) begin
        s1_op <= bus.op;
        s1_a  <= bus.a;
        s1_b  <= bus.b;
      end
      // acc is written as the result enters S2, so a following ACC in S1 already sees it
      if (!stall) begin
        bus.out_valid <= s1_v;
        if (s1_v) begin
          bus.y   <= res;
          bus.ovf <= res_ovf;
          if (s1_op == OP_ACC || s1_op == OP_LOAD) acc <= res;
        end
      end
      if (bus.out_valid && bus.out_ready && bus.ovf) bus.ovf_sticky <= 1'b1;
      else if (bus.clr_sticky) bus.ovf_sticky <= 1'b0;
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed checks of addsub_pipe in wrap (i0) and saturating (i1) modes
module tb_addsub_pipe;
  import addsub_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;
  addsub_pipe_if #(.W(12)) i0 ();
  addsub_pipe_if #(.W(12)) i1 ();
  addsub_pipe #(.W(12), .SAT(0)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  addsub_pipe #(.W(12), .SAT(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive0(input logic v, input logic [OP_W-1:0] o, input logic [11:0] x, input logic [11:0] z);
    i0.in_valid = v;
    i0.op = o;
    i0.a = x;
    i0.b = z;
  endtask
  task automatic drive1(input logic v, input logic [OP_W-1:0] o, input logic [11:0] x, input logic [11:0] z);
    i1.in_valid = v;
    i1.op = o;
    i1.a = x;
    i1.b = z;
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end
  initial begin
    drive0(1'b0, OP_ADD, 12'h0, 12'h0);
    drive1(1'b0, OP_ADD, 12'h0, 12'h0);
    i0.out_ready = 1'b1;
    i0.clr_sticky = 1'b0;
    i1.out_ready = 1'b1;
    i1.clr_sticky = 1'b0;
    #1;
    chk("rst_in_ready", i0.in_ready, 0);
    chk("rst_out_valid", i0.out_valid, 0);
    chk("rst_sticky", i0.ovf_sticky, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rel_in_ready_low", i0.in_ready, 0);
    tick();
    chk("rel_in_ready_high", i0.in_ready, 1);
    drive0(1'b1, OP_ADD, 12'hFFF, 12'h002);
    tick();
    drive0(1'b0, OP_ADD, 12'h0, 12'h0);
    chk("add_lat1_valid", i0.out_valid, 0);
    tick();
    chk("add_valid", i0.out_valid, 1);
    chk("add_y", i0.y, 12'h001);
    chk("add_ovf", i0.ovf, 1);
    chk("add_sticky_pre", i0.ovf_sticky, 0);
    tick();
    chk("add_sticky", i0.ovf_sticky, 1);
    chk("add_drained", i0.out_valid, 0);
    i0.clr_sticky = 1'b1;
    tick();
    i0.clr_sticky = 1'b0;
    chk("clr_sticky", i0.ovf_sticky, 0);
    drive0(1'b1, OP_LOAD, 12'h010, 12'h7AB);
    tick();
    drive0(1'b1, OP_ACC, 12'h005, 12'h3CD);
    tick();
    drive0(1'b1, OP_ACC, 12'h003, 12'hFFF);
    chk("load_y", i0.y, 12'h010);
    chk("load_ovf", i0.ovf, 0);
    tick();
    drive0(1'b0, OP_ADD, 12'h0, 12'h0);
    chk("acc1_y", i0.y, 12'h015);
    chk("acc1_ovf", i0.ovf, 0);
    tick();
    chk("acc2_y", i0.y, 12'h018);
    chk("acc2_ovf", i0.ovf, 0);
    tick();
    chk("acc_drained", i0.out_valid, 0);
    i0.out_ready = 1'b0;
    drive0(1'b1, OP_ADD, 12'h001, 12'h002);
    #1;
    chk("stall_rdy1", i0.in_ready, 1);
    tick();
    drive0(1'b1, OP_SUB, 12'h009, 12'h004);
    #1;
    chk("stall_rdy2", i0.in_ready, 1);
    tick();
    drive0(1'b1, OP_LOAD, 12'h007, 12'h000);
    #1;
    chk("stall_rdy3", i0.in_ready, 0);
    chk("stall_y0", i0.y, 12'h003);
    tick();
    chk("stall_rdy4", i0.in_ready, 0);
    chk("stall_y1", i0.y, 12'h003);
    tick();
    chk("stall_y2", i0.y, 12'h003);
    chk("stall_valid", i0.out_valid, 1);
    drive0(1'b0, OP_ADD, 12'h0, 12'h0);
    i0.out_ready = 1'b1;
    tick();
    chk("rel_y_second", i0.y, 12'h005);
    chk("rel_valid_second", i0.out_valid, 1);
    tick();
    chk("rel_no_dup", i0.out_valid, 0);
    drive0(1'b1, OP_ADD, 12'h001, 12'h001);
    tick();
    drive0(1'b1, OP_ADD, 12'h002, 12'h002);
    tick();
    drive0(1'b0, OP_ADD, 12'h0, 12'h0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", i0.out_valid, 0);
    chk("midrst_rdy", i0.in_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_rdy", i0.in_ready, 1);
    chk("postrst_valid", i0.out_valid, 0);
    drive0(1'b1, OP_LOAD, 12'h123, 12'h000);
    tick();
    drive0(1'b0, OP_ADD, 12'h0, 12'h0);
    chk("postrst_empty", i0.out_valid, 0);
    tick();
    chk("postrst_y", i0.y, 12'h123);
    chk("postrst_v", i0.out_valid, 1);
    drive0(1'b1, OP_ADD, 12'hFFF, 12'h001);
    tick();
    drive0(1'b0, OP_ADD, 12'h0, 12'h0);
    tick();
    chk("setclr_ovf", i0.ovf, 1);
    i0.clr_sticky = 1'b1;
    tick();
    i0.clr_sticky = 1'b0;
    chk("setclr_wins", i0.ovf_sticky, 1);
    i0.clr_sticky = 1'b1;
    tick();
    i0.clr_sticky = 1'b0;
    chk("clr_alone", i0.ovf_sticky, 0);
    drive1(1'b1, OP_SUB, 12'h005, 12'h009);
    tick();
    drive1(1'b1, OP_ADD, 12'h800, 12'h800);
    tick();
    drive1(1'b0, OP_ADD, 12'h0, 12'h0);
    chk("sat_sub_y", i1.y, 12'h000);
    chk("sat_sub_ovf", i1.ovf, 1);
    tick();
    chk("sat_add_y", i1.y, 12'hFFF);
    chk("sat_add_ovf", i1.ovf, 1);
    tick();
    chk("sat_sticky", i1.ovf_sticky, 1);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
